// File: rtl/shield_write_mstr.sv
// Write-side shield master: encrypts an evicted plaintext line, writes the ciphertext line over AXI4,
// then writes its HMAC tag into the packed tag region with a strobe that leaves neighbour tags untouched.
module shield_write_mstr #(
  parameter int AXI_ADDR_WIDTH    = 64,
  parameter int AXI_ID_WIDTH      = 16,
  parameter int AXI_DATA_WIDTH    = 512,
  parameter int SHIELD_ADDR_WIDTH = 32,
  parameter int LINE_WIDTH        = 512,
  parameter int OFFSET_WIDTH      = 6,
  parameter logic [AXI_ADDR_WIDTH-1:0] TAG_BASE_ADDR = 64'h1_0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SHIELD_ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0]        req_data,
  input  logic                         req_val,
  output logic                         req_rdy,
  output logic [SHIELD_ADDR_WIDTH-1:0] enc_req_addr,
  output logic [LINE_WIDTH-1:0]        enc_req_data,
  output logic                         enc_req_val,
  input  logic                         enc_req_rdy,
  input  logic [LINE_WIDTH-1:0]        enc_resp_pad,
  input  logic [127:0]                 enc_resp_tag,
  input  logic                         enc_resp_val,
  output logic                         enc_resp_rdy,
  output logic                         busy,
  output logic                         error,
  output logic [2:0]                   state_dbg,
  output logic [AXI_ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]      m_axi_awid,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic                         m_axi_awlock,
  output logic [3:0]                   m_axi_awcache,
  output logic [2:0]                   m_axi_awprot,
  output logic [3:0]                   m_axi_awqos,
  output logic [3:0]                   m_axi_awregion,
  output logic [AXI_DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]  m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready
);
  localparam int HMAC_TAG_WIDTH = 128;
  localparam int TAGS_PER_LINE  = 4;
  localparam int TAG_SEL_W      = $clog2(TAGS_PER_LINE);
  localparam int GRP_LSB        = OFFSET_WIDTH + TAG_SEL_W;
  localparam int STRB_W         = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ENC_REQ, S_ENC_WAIT, S_WR_DATA, S_B_DATA, S_WR_TAG, S_B_TAG, S_FAIL
  } state_t;

  // Every valid/ready below follows the same rule: a transfer happens on a rising edge where
  // both valid and ready are high; a raised valid keeps its payload stable until that edge.
  state_t                        state_q, state_d;
  logic [SHIELD_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]         line_q, line_d;
  logic [HMAC_TAG_WIDTH-1:0]     tag_q, tag_d;
  logic [AXI_ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic req_rdy_q, req_rdy_d, enc_req_val_q, enc_req_val_d;
  logic enc_resp_rdy_q, enc_resp_rdy_d, error_q, error_d;

  logic [SHIELD_ADDR_WIDTH-1:0] line_addr;
  logic [AXI_ADDR_WIDTH-1:0]    tag_awaddr;
  logic [TAG_SEL_W-1:0]         tag_sel;
  logic [LINE_WIDTH-1:0]        tag_wdata;
  logic [STRB_W-1:0]            tag_strb;
  logic                         unused_addr_bits;

  assign line_addr = {addr_q[SHIELD_ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  // One 64B tag line packs the tags of four consecutive data lines, hence the >> TAG_SEL_W.
  assign tag_awaddr = TAG_BASE_ADDR +
    (AXI_ADDR_WIDTH'({addr_q[SHIELD_ADDR_WIDTH-1:GRP_LSB], {GRP_LSB{1'b0}}}) >> TAG_SEL_W);
  assign tag_sel   = addr_q[OFFSET_WIDTH +: TAG_SEL_W];
  assign tag_wdata = LINE_WIDTH'(tag_q) << (32'(tag_sel) * HMAC_TAG_WIDTH);
  assign tag_strb  = STRB_W'({(HMAC_TAG_WIDTH/8){1'b1}}) << (32'(tag_sel) * (HMAC_TAG_WIDTH/8));
  assign unused_addr_bits = ^addr_q[OFFSET_WIDTH-1:0];

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    line_d         = line_q;
    tag_d          = tag_q;
    awaddr_d       = awaddr_q;
    wstrb_d        = wstrb_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    req_rdy_d      = req_rdy_q;
    enc_req_val_d  = enc_req_val_q;
    enc_resp_rdy_d = enc_resp_rdy_q;
    error_d        = error_q;
    case (state_q)
      S_IDLE: if (req_val && req_rdy_q) begin
        addr_d        = req_addr;
        line_d        = req_data;
        req_rdy_d     = 1'b0;
        enc_req_val_d = 1'b1;
        state_d       = S_ENC_REQ;
      end
      S_ENC_REQ: if (enc_req_rdy) begin
        enc_req_val_d  = 1'b0;
        enc_resp_rdy_d = 1'b1;
        state_d        = S_ENC_WAIT;
      end
      S_ENC_WAIT: if (enc_resp_val) begin
        enc_resp_rdy_d = 1'b0;
        line_d         = line_q ^ enc_resp_pad;
        tag_d          = enc_resp_tag;
        awaddr_d       = AXI_ADDR_WIDTH'(line_addr);
        wstrb_d        = '1;
        awvalid_d      = 1'b1;
        wvalid_d       = 1'b1;
        state_d        = S_WR_DATA;
      end
      S_WR_DATA, S_WR_TAG: begin
        // AW and W retire independently; a dropped valid doubles as that channel's done flag.
        awvalid_d = awvalid_q && !m_axi_awready;
        wvalid_d  = wvalid_q && !m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = (state_q == S_WR_DATA) ? S_B_DATA : S_B_TAG;
        end
      end
      S_B_DATA: if (m_axi_bvalid) begin
        bready_d = 1'b0;
        if (m_axi_bresp == 2'b00) begin
          // Ciphertext is no longer needed once DRAM acknowledged it; reuse the line register.
          line_d    = tag_wdata;
          awaddr_d  = tag_awaddr;
          wstrb_d   = tag_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR_TAG;
        end else begin
          error_d = 1'b1;
          state_d = S_FAIL;
        end
      end
      S_B_TAG: if (m_axi_bvalid) begin
        bready_d = 1'b0;
        if (m_axi_bresp == 2'b00) begin
          req_rdy_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          error_d = 1'b1;
          state_d = S_FAIL;
        end
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_FAIL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      line_q         <= '0;
      tag_q          <= '0;
      awaddr_q       <= '0;
      wstrb_q        <= '0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      req_rdy_q      <= 1'b1;
      enc_req_val_q  <= 1'b0;
      enc_resp_rdy_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      line_q         <= line_d;
      tag_q          <= tag_d;
      awaddr_q       <= awaddr_d;
      wstrb_q        <= wstrb_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      req_rdy_q      <= req_rdy_d;
      enc_req_val_q  <= enc_req_val_d;
      enc_resp_rdy_q <= enc_resp_rdy_d;
      error_q        <= error_d;
    end
  end

  assign req_rdy        = req_rdy_q;
  assign enc_req_addr   = line_addr;
  assign enc_req_data   = line_q;
  assign enc_req_val    = enc_req_val_q;
  assign enc_resp_rdy   = enc_resp_rdy_q;
  assign busy           = (state_q != S_IDLE);
  assign error          = error_q;
  assign state_dbg      = state_q;
  assign m_axi_awaddr   = awaddr_q;
  assign m_axi_awvalid  = awvalid_q;
  assign m_axi_awid     = '0;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = 3'b110;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_wdata    = line_q;
  assign m_axi_wstrb    = wstrb_q;
  assign m_axi_wlast    = 1'b1;
  assign m_axi_wvalid   = wvalid_q;
  assign m_axi_bready   = bready_q;
endmodule
